// File: rtl/i2c_pkg.sv
// Shared I2C definitions: master command codes, sequencer step list and
// the helpers that walk the step list for write and read transactions.
package i2c_pkg;

    localparam logic [2:0] CMD_START   = 3'b000;
    localparam logic [2:0] CMD_WR      = 3'b001;
    localparam logic [2:0] CMD_RD      = 3'b010;
    localparam logic [2:0] CMD_STOP    = 3'b011;
    localparam logic [2:0] CMD_RESTART = 3'b100;

    typedef enum logic [2:0] {
        STEP_START,
        STEP_ADDR_W,
        STEP_REG,
        STEP_WDATA,
        STEP_RESTART,
        STEP_ADDR_R,
        STEP_READ,
        STEP_STOP
    } step_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_WAIT_RDY,
        ST_RESP
    } seq_state_e;

    function automatic logic [2:0] step_cmd(step_e s);
        case (s)
            STEP_START:   return CMD_START;
            STEP_RESTART: return CMD_RESTART;
            STEP_READ:    return CMD_RD;
            STEP_STOP:    return CMD_STOP;
            default:      return CMD_WR;
        endcase
    endfunction

    // Write: START, ADDR_W, REG, WDATA, STOP.
    // Read:  START, ADDR_W, REG, RESTART, ADDR_R, READ, STOP.
    function automatic step_e step_next(logic rnw, step_e s);
        case (s)
            STEP_START:   return STEP_ADDR_W;
            STEP_ADDR_W:  return STEP_REG;
            STEP_REG:     return rnw ? STEP_RESTART : STEP_WDATA;
            STEP_RESTART: return STEP_ADDR_R;
            STEP_ADDR_R:  return STEP_READ;
            default:      return STEP_STOP;
        endcase
    endfunction

endpackage

// File: rtl/i2c_seq_watchdog.sv
// Per-handshake watchdog: counts while enabled, clears on request, and
// flags expiry on the TIMEOUT-th cycle. TIMEOUT of zero disables it.
module i2c_seq_watchdog #(
    parameter int unsigned     TO_W    = 20,
    parameter logic [TO_W-1:0] TIMEOUT = 20'd1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic expired
);

    localparam logic [TO_W-1:0] LAST = TIMEOUT - TO_W'(1);

    logic [TO_W-1:0] cnt_q, cnt_d;

    always_comb begin
        expired = (TIMEOUT != '0) && en && (cnt_q == LAST);
        cnt_d   = cnt_q;
        if (clr || !en) begin
            cnt_d = '0;
        end else if (!expired) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/i2c_reg_seq.sv
// Register-access sequencer: turns one write/read request into the byte
// master's START/WR/RD/RESTART/STOP stream and returns one response.
module i2c_reg_seq
    import i2c_pkg::*;
#(
    parameter int unsigned     TO_W    = 20,
    parameter logic [TO_W-1:0] TIMEOUT = 20'd1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rnw,
    input  logic [6:0] req_dev,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       rsp_timeout,
    output logic [2:0] m_cmd,
    output logic [7:0] m_din,
    output logic       m_wr_i2c,
    input  logic       m_ready,
    input  logic       m_done_tick,
    input  logic       m_ack,
    input  logic [7:0] m_dout
);

    seq_state_e state_q, state_d;
    step_e      step_q, step_d;
    logic       rnw_q, rnw_d;
    logic [6:0] dev_q, dev_d;
    logic [7:0] reg_q, reg_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic       nack_q, nack_d;
    logic [7:0] rsp_rdata_q, rsp_rdata_d;
    logic       rsp_nack_q, rsp_nack_d;
    logic       rsp_timeout_q, rsp_timeout_d;

    logic       wd_en, wd_clr, wd_expired;
    logic [2:0] cur_cmd;

    i2c_seq_watchdog #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_wd (
        .clk     (clk),
        .reset   (reset),
        .en      (wd_en),
        .clr     (wd_clr),
        .expired (wd_expired)
    );

    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        rnw_d         = rnw_q;
        dev_d         = dev_q;
        reg_d         = reg_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        nack_d        = nack_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_nack_d    = rsp_nack_q;
        rsp_timeout_d = rsp_timeout_q;

        cur_cmd   = step_cmd(step_q);
        wd_en     = (state_q == ST_ISSUE) || (state_q == ST_WAIT_DONE) ||
                    (state_q == ST_WAIT_RDY);
        req_ready = (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
        m_wr_i2c  = (state_q == ST_ISSUE) && m_ready && !wd_expired;
        m_cmd     = cur_cmd;

        case (step_q)
            STEP_ADDR_W: m_din = {dev_q, 1'b0};
            STEP_REG:    m_din = reg_q;
            STEP_WDATA:  m_din = wdata_q;
            STEP_ADDR_R: m_din = {dev_q, 1'b1};
            STEP_READ:   m_din = 8'hFF;
            default:     m_din = 8'h00;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    rnw_d   = req_rnw;
                    dev_d   = req_dev;
                    reg_d   = req_reg;
                    wdata_d = req_wdata;
                    rdata_d = 8'h00;
                    nack_d  = 1'b0;
                    step_d  = STEP_START;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (m_ready) begin
                    state_d = (cur_cmd == CMD_WR || cur_cmd == CMD_RD) ?
                              ST_WAIT_DONE : ST_WAIT_RDY;
                end
            end
            ST_WAIT_DONE: begin
                if (m_done_tick) begin
                    // On RD the ack bit is the master's own NACK, not the slave's.
                    if (cur_cmd == CMD_WR && m_ack) nack_d = 1'b1;
                    if (cur_cmd == CMD_RD) rdata_d = m_dout;
                    state_d = ST_WAIT_RDY;
                end
            end
            ST_WAIT_RDY: begin
                if (m_ready) begin
                    if (step_q == STEP_STOP) begin
                        state_d = ST_RESP;
                    end else begin
                        step_d  = nack_q ? STEP_STOP : step_next(rnw_q, step_q);
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_RESP: begin
                step_d  = STEP_START;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Watchdog abandons the transfer without a STOP.
        if (wd_expired) state_d = ST_RESP;

        if (state_d == ST_RESP && state_q != ST_RESP) begin
            rsp_timeout_d = wd_expired;
            rsp_nack_d    = !wd_expired && nack_q;
            rsp_rdata_d   = (wd_expired || nack_q) ? 8'h00 : rdata_q;
        end

        wd_clr = (state_d != state_q);
    end

    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_nack    = rsp_nack_q;
    assign rsp_timeout = rsp_timeout_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            step_q        <= STEP_START;
            rnw_q         <= 1'b0;
            dev_q         <= 7'h00;
            reg_q         <= 8'h00;
            wdata_q       <= 8'h00;
            rdata_q       <= 8'h00;
            nack_q        <= 1'b0;
            rsp_rdata_q   <= 8'h00;
            rsp_nack_q    <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            rnw_q         <= rnw_d;
            dev_q         <= dev_d;
            reg_q         <= reg_d;
            wdata_q       <= wdata_d;
            rdata_q       <= rdata_d;
            nack_q        <= nack_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_nack_q    <= rsp_nack_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

endmodule

// File: tb/tb_i2c_reg_seq.sv
// Directed bench for i2c_reg_seq with a small reactive byte-master model.
module tb_i2c_reg_seq;
    import i2c_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid, req_ready, req_rnw;
    logic [6:0] req_dev;
    logic [7:0] req_reg, req_wdata;
    logic       rsp_valid, rsp_nack, rsp_timeout;
    logic [7:0] rsp_rdata;
    logic [2:0] m_cmd;
    logic [7:0] m_din, m_dout;
    logic       m_wr_i2c, m_ready, m_done_tick, m_ack;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    i2c_reg_seq #(.TO_W(20), .TIMEOUT(20'd100)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
        .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack),
        .rsp_timeout(rsp_timeout),
        .m_cmd(m_cmd), .m_din(m_din), .m_wr_i2c(m_wr_i2c), .m_ready(m_ready),
        .m_done_tick(m_done_tick), .m_ack(m_ack), .m_dout(m_dout)
    );

    // Byte-master model: leaves hold on a strobe, busy a few cycles, then
    // (for byte commands) pulses done together with returning to hold.
    logic       stuck = 1'b0, nack_en = 1'b0, busy = 1'b0;
    logic [7:0] nack_byte = 8'h00, rd_byte = 8'h00, cap_din = 8'h00;
    logic [2:0] cap_cmd = 3'b000;
    int         busy_cnt = 0;

    always @(posedge clk) begin
        m_done_tick <= 1'b0;
        if (reset) begin
            m_ready <= 1'b1; busy <= 1'b0; busy_cnt <= 0;
            m_ack <= 1'b0; m_dout <= 8'h00;
        end else if (busy) begin
            if (busy_cnt != 0) begin
                busy_cnt <= busy_cnt - 1;
            end else begin
                busy    <= 1'b0;
                m_ready <= !stuck;
                if (cap_cmd == CMD_WR || cap_cmd == CMD_RD) begin
                    m_done_tick <= 1'b1;
                    m_ack <= (cap_cmd == CMD_RD) ? 1'b1 : (nack_en && cap_din == nack_byte);
                    if (cap_cmd == CMD_RD) m_dout <= rd_byte;
                end
            end
        end else if (m_wr_i2c && m_ready) begin
            busy <= 1'b1; busy_cnt <= 3; m_ready <= 1'b0;
            cap_cmd <= m_cmd; cap_din <= m_din;
        end else begin
            m_ready <= !stuck;
        end
    end

    // Strobe and response logs, sampled on the falling edge.
    logic [2:0] cmd_log[$];
    logic [7:0] din_log[$];
    logic [7:0] r_rdata[$];
    logic       r_nack[$];
    logic       r_to[$];
    int         viol = 0;
    logic       prev_wr = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            if (m_wr_i2c) begin
                if (busy || prev_wr) viol++;
                cmd_log.push_back(m_cmd);
                din_log.push_back(m_din);
            end
            if (rsp_valid) begin
                r_rdata.push_back(rsp_rdata);
                r_nack.push_back(rsp_nack);
                r_to.push_back(rsp_timeout);
            end
        end
        prev_wr = m_wr_i2c;
    end

    task automatic clear_logs();
        cmd_log.delete(); din_log.delete();
        r_rdata.delete(); r_nack.delete(); r_to.delete();
        viol = 0;
    endtask

    // Present a request at a falling edge, wait for acceptance, then drop it
    // and scramble the fields so late changes would be visible.
    task automatic send(input logic rnw, input logic [6:0] dev, input logic [7:0] rg,
                        input logic [7:0] wd, output bit ok);
        req_rnw = rnw; req_dev = dev; req_reg = rg; req_wdata = wd; req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (req_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (ok) begin @(posedge clk); @(negedge clk); end
        req_valid = 1'b0;
        req_rnw = ~rnw; req_dev = ~dev; req_reg = ~rg; req_wdata = ~wd;
    endtask

    task automatic wait_rsp(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (r_rdata.size() >= n) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        total++; if (m_wr_i2c !== 1'b0) begin bad++; $display("FAIL reset_m_wr_i2c got=%b exp=0", m_wr_i2c); end
        total++; if (m_cmd !== 3'b000) begin bad++; $display("FAIL reset_m_cmd got=%h exp=0", m_cmd); end
        total++; if (m_din !== 8'h00) begin bad++; $display("FAIL reset_m_din got=%h exp=0", m_din); end
        total++; if (rsp_rdata !== 8'h00) begin bad++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
        total++; if (rsp_nack !== 1'b0) begin bad++; $display("FAIL reset_rsp_nack got=%b exp=0", rsp_nack); end
        total++; if (rsp_timeout !== 1'b0) begin bad++; $display("FAIL reset_rsp_timeout got=%b exp=0", rsp_timeout); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write();
        logic [2:0] ec[5] = '{CMD_START, CMD_WR, CMD_WR, CMD_WR, CMD_STOP};
        logic [7:0] ed[5] = '{8'h00, 8'hA0, 8'h10, 8'hA5, 8'h00};
        bit ok;
        clear_logs(); nack_en = 1'b0;
        send(1'b0, 7'h50, 8'h10, 8'hA5, ok);
        total++; if (!ok) begin bad++; $display("FAIL wr_accept got=timeout exp=accepted"); end
        wait_rsp(1, ok);
        total++; if (r_rdata.size() != 1) begin bad++; $display("FAIL wr_rsp_count got=%0d exp=1", r_rdata.size()); end
        total++; if (cmd_log.size() != 5) begin bad++; $display("FAIL wr_strobe_count got=%0d exp=5", cmd_log.size()); end
        for (int i = 0; i < 5 && i < cmd_log.size(); i++) begin
            total++; if (cmd_log[i] !== ec[i]) begin bad++; $display("FAIL wr_cmd[%0d] got=%h exp=%h", i, cmd_log[i], ec[i]); end
            if (ec[i] == CMD_WR) begin
                total++; if (din_log[i] !== ed[i]) begin bad++; $display("FAIL wr_din[%0d] got=%h exp=%h", i, din_log[i], ed[i]); end
            end
        end
        if (r_rdata.size() > 0) begin
            total++; if (r_rdata[0] !== 8'h00) begin bad++; $display("FAIL wr_rdata got=%h exp=00", r_rdata[0]); end
            total++; if (r_nack[0] !== 1'b0) begin bad++; $display("FAIL wr_nack got=%b exp=0", r_nack[0]); end
            total++; if (r_to[0] !== 1'b0) begin bad++; $display("FAIL wr_timeout got=%b exp=0", r_to[0]); end
        end
        total++; if (viol != 0) begin bad++; $display("FAIL wr_strobe_rule got=%0d exp=0", viol); end
    endtask

    task automatic test_read();
        logic [2:0] ec[7] = '{CMD_START, CMD_WR, CMD_WR, CMD_RESTART, CMD_WR, CMD_RD, CMD_STOP};
        logic [7:0] ed[7] = '{8'h00, 8'hA0, 8'h20, 8'h00, 8'hA1, 8'hFF, 8'h00};
        bit ok;
        clear_logs(); nack_en = 1'b0; rd_byte = 8'h3C;
        send(1'b1, 7'h50, 8'h20, 8'h00, ok);
        total++; if (!ok) begin bad++; $display("FAIL rd_accept got=timeout exp=accepted"); end
        wait_rsp(1, ok);
        total++; if (r_rdata.size() != 1) begin bad++; $display("FAIL rd_rsp_count got=%0d exp=1", r_rdata.size()); end
        total++; if (cmd_log.size() != 7) begin bad++; $display("FAIL rd_strobe_count got=%0d exp=7", cmd_log.size()); end
        for (int i = 0; i < 7 && i < cmd_log.size(); i++) begin
            total++; if (cmd_log[i] !== ec[i]) begin bad++; $display("FAIL rd_cmd[%0d] got=%h exp=%h", i, cmd_log[i], ec[i]); end
            if (ec[i] == CMD_WR || ec[i] == CMD_RD) begin
                total++; if (din_log[i] !== ed[i]) begin bad++; $display("FAIL rd_din[%0d] got=%h exp=%h", i, din_log[i], ed[i]); end
            end
        end
        if (r_rdata.size() > 0) begin
            total++; if (r_rdata[0] !== 8'h3C) begin bad++; $display("FAIL rd_rdata got=%h exp=3c", r_rdata[0]); end
            total++; if (r_nack[0] !== 1'b0) begin bad++; $display("FAIL rd_nack got=%b exp=0", r_nack[0]); end
        end
    endtask

    task automatic test_read_nack();
        bit ok;
        clear_logs(); nack_en = 1'b1; nack_byte = 8'hA0; rd_byte = 8'h3C;
        send(1'b1, 7'h50, 8'h20, 8'h00, ok);
        total++; if (!ok) begin bad++; $display("FAIL nk_accept got=timeout exp=accepted"); end
        wait_rsp(1, ok);
        nack_en = 1'b0;
        total++; if (cmd_log.size() != 3) begin bad++; $display("FAIL nk_strobe_count got=%0d exp=3", cmd_log.size()); end
        if (cmd_log.size() >= 3) begin
            total++; if (din_log[1] !== 8'hA0) begin bad++; $display("FAIL nk_addr got=%h exp=a0", din_log[1]); end
            total++; if (cmd_log[2] !== CMD_STOP) begin bad++; $display("FAIL nk_next_stop got=%h exp=3", cmd_log[2]); end
        end
        total++; if (r_rdata.size() != 1) begin bad++; $display("FAIL nk_rsp_count got=%0d exp=1", r_rdata.size()); end
        if (r_rdata.size() > 0) begin
            total++; if (r_nack[0] !== 1'b1) begin bad++; $display("FAIL nk_nack got=%b exp=1", r_nack[0]); end
            total++; if (r_rdata[0] !== 8'h00) begin bad++; $display("FAIL nk_rdata got=%h exp=00", r_rdata[0]); end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        clear_logs(); stuck = 1'b1;
        @(negedge clk);
        send(1'b0, 7'h50, 8'h10, 8'hA5, ok);
        total++; if (!ok) begin bad++; $display("FAIL to_accept got=timeout exp=accepted"); end
        n = 0;
        while (!rsp_valid && n < 300) begin @(negedge clk); n++; end
        total++; if (n != 100) begin bad++; $display("FAIL to_latency got=%0d exp=100", n); end
        total++; if (rsp_timeout !== 1'b1) begin bad++; $display("FAIL to_flag got=%b exp=1", rsp_timeout); end
        total++; if (rsp_nack !== 1'b0) begin bad++; $display("FAIL to_nack got=%b exp=0", rsp_nack); end
        total++; if (rsp_rdata !== 8'h00) begin bad++; $display("FAIL to_rdata got=%h exp=00", rsp_rdata); end
        @(negedge clk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL to_ready_after got=%b exp=1", req_ready); end
        total++; if (cmd_log.size() != 0) begin bad++; $display("FAIL to_no_strobes got=%0d exp=0", cmd_log.size()); end
        stuck = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n;
        clear_logs(); rd_byte = 8'h5A;
        req_rnw = 1'b0; req_dev = 7'h50; req_reg = 8'h01; req_wdata = 8'h77; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 300) begin @(negedge clk); n++; end
        @(posedge clk); @(negedge clk);
        req_rnw = 1'b1; req_dev = 7'h21; req_reg = 8'h33; req_wdata = 8'h00;
        n = 0;
        while (!rsp_valid && n < 2000) begin @(negedge clk); n++; end
        total++; if (!rsp_valid) begin bad++; $display("FAIL b2b_first_rsp got=none exp=rsp_valid"); end
        @(negedge clk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_after_rsp got=%b exp=1", req_ready); end
        @(negedge clk);
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL b2b_second_accept got=%b exp=0", req_ready); end
        req_valid = 1'b0;
        wait_rsp(2, ok);
        total++; if (r_rdata.size() != 2) begin bad++; $display("FAIL b2b_rsp_count got=%0d exp=2", r_rdata.size()); end
        if (r_rdata.size() == 2) begin
            total++; if (r_rdata[0] !== 8'h00 || r_nack[0] !== 1'b0) begin bad++; $display("FAIL b2b_rsp0 got=%h/%b exp=00/0", r_rdata[0], r_nack[0]); end
            total++; if (r_rdata[1] !== 8'h5A || r_nack[1] !== 1'b0) begin bad++; $display("FAIL b2b_rsp1 got=%h/%b exp=5a/0", r_rdata[1], r_nack[1]); end
        end
        total++; if (cmd_log.size() != 12) begin bad++; $display("FAIL b2b_strobe_count got=%0d exp=12", cmd_log.size()); end
        if (cmd_log.size() == 12) begin
            total++; if (din_log[3] !== 8'h77) begin bad++; $display("FAIL b2b_wdata got=%h exp=77", din_log[3]); end
            total++; if (din_log[6] !== 8'h42) begin bad++; $display("FAIL b2b_addr_w got=%h exp=42", din_log[6]); end
            total++; if (din_log[7] !== 8'h33) begin bad++; $display("FAIL b2b_reg got=%h exp=33", din_log[7]); end
            total++; if (din_log[9] !== 8'h43) begin bad++; $display("FAIL b2b_addr_r got=%h exp=43", din_log[9]); end
        end
        total++; if (viol != 0) begin bad++; $display("FAIL b2b_strobe_rule got=%0d exp=0", viol); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n;
        clear_logs();
        req_rnw = 1'b0; req_dev = 7'h50; req_reg = 8'h10; req_wdata = 8'hA5; req_valid = 1'b1;
        n = 0;
        while (cmd_log.size() < 3 && n < 2000) begin
            @(negedge clk); n++;
            if (!req_ready) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%b exp=1", req_ready); end
        total++; if (m_wr_i2c !== 1'b0) begin bad++; $display("FAIL rst_mid_wr got=%b exp=0", m_wr_i2c); end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (r_rdata.size() != 0) begin bad++; $display("FAIL rst_mid_no_rsp got=%0d exp=0", r_rdata.size()); end
        clear_logs();
        send(1'b0, 7'h12, 8'h34, 8'h56, ok);
        wait_rsp(1, ok);
        total++; if (cmd_log.size() != 5) begin bad++; $display("FAIL rst_after_strobes got=%0d exp=5", cmd_log.size()); end
        if (cmd_log.size() == 5) begin
            total++; if (din_log[1] !== 8'h24 || din_log[2] !== 8'h34 || din_log[3] !== 8'h56) begin
                bad++; $display("FAIL rst_after_bytes got=%h %h %h exp=24 34 56", din_log[1], din_log[2], din_log[3]);
            end
        end
        total++; if (r_rdata.size() != 1) begin bad++; $display("FAIL rst_after_rsp got=%0d exp=1", r_rdata.size()); end
        else begin
            total++; if (r_nack[0] !== 1'b0 || r_to[0] !== 1'b0) begin bad++; $display("FAIL rst_after_flags got=%b/%b exp=0/0", r_nack[0], r_to[0]); end
        end
    endtask

    initial begin
        req_valid = 1'b0; req_rnw = 1'b0; req_dev = 7'h00; req_reg = 8'h00; req_wdata = 8'h00;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        test_write();
        test_read();
        test_read_nack();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit got=running exp=finished");
        $fatal(1);
    end

endmodule
